// File: rtl/fetch_unit_pkg.sv
// Shared processor-wide types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC     = 32'd4;
  localparam logic [WORD_W-1:0] R15_OFFSET = 32'd8;
  localparam logic [WORD_W-1:0] NOP_INSTR  = 32'hE1A0_0000;
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Force an address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_register.sv
// Program counter flop with priority update: branch redirect, then increment, then hold.
module pc_register
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              inc_en,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_next
);

  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] pc_next_s;

  // Next-PC priority mux.
  always_comb begin
    pc_next_s = pc_r;
    if (branch_taken) begin
      pc_next_s = align_word(branch_target);
    end else if (inc_en) begin
      pc_next_s = pc_r + PC_INC;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pc      = pc_r;
  assign pc_next = pc_next_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the imem handshake and holds one
// fetched instruction with its R15 read value for the register file/decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              imem_ready,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] r15
);

  fetch_state_t      state_r;
  fetch_state_t      next_state_s;
  logic              imem_req_r;
  logic [WORD_W-1:0] imem_addr_r;
  logic [WORD_W-1:0] instr_r;
  logic [WORD_W-1:0] r15_r;
  logic              instr_valid_r;
  logic              instr_valid_next_s;
  logic              load_addr_s;
  logic              load_instr_s;
  logic              inc_en_s;
  logic [WORD_W-1:0] pc_s;
  logic [WORD_W-1:0] pc_next_s;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk           (clk),
    .reset         (reset),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .inc_en        (inc_en_s),
    .pc            (pc_s),
    .pc_next       (pc_next_s)
  );

  // Next-state and datapath enables; branch outranks ready and stall everywhere.
  always_comb begin
    next_state_s = state_r;
    load_addr_s  = 1'b0;
    load_instr_s = 1'b0;
    inc_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = FETCH;
        load_addr_s  = 1'b1;
      end
      FETCH: begin
        if (branch_taken) begin
          if (imem_ready) begin
            next_state_s = FETCH;
            load_addr_s  = 1'b1;
          end else begin
            next_state_s = DROP;
          end
        end else if (imem_ready) begin
          // A full, stalled slot cannot take the data: drop it and refetch the
          // same pc once the slot drains, so no instruction is lost.
          if (instr_valid_r && stall) begin
            next_state_s = HOLD;
          end else begin
            next_state_s = FETCH;
            load_instr_s = 1'b1;
            inc_en_s     = 1'b1;
            load_addr_s  = 1'b1;
          end
        end else begin
          next_state_s = FETCH;
        end
      end
      HOLD: begin
        if (branch_taken || !stall) begin
          next_state_s = FETCH;
          load_addr_s  = 1'b1;
        end else begin
          next_state_s = HOLD;
        end
      end
      DROP: begin
        if (imem_ready) begin
          next_state_s = FETCH;
          load_addr_s  = 1'b1;
        end else begin
          next_state_s = DROP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Instruction slot occupancy: flush, load, consume, or keep.
  always_comb begin
    instr_valid_next_s = instr_valid_r;
    if (branch_taken) begin
      instr_valid_next_s = 1'b0;
    end else if (load_instr_s) begin
      instr_valid_next_s = 1'b1;
    end else if (instr_valid_r && !stall) begin
      instr_valid_next_s = 1'b0;
    end else begin
      instr_valid_next_s = instr_valid_r;
    end
  end

  // State, request and instruction-slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      r15_r         <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      imem_req_r    <= (next_state_s == FETCH) || (next_state_s == DROP);
      instr_valid_r <= instr_valid_next_s;
      if (load_addr_s) begin
        imem_addr_r <= pc_next_s;
      end
      if (load_instr_s) begin
        instr_r <= imem_rdata;
        r15_r   <= imem_addr_r + R15_OFFSET;
      end
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_s;
  assign r15         = r15_r;

endmodule
